// File: rtl/bec_pkg.sv
// Shared encodings for the BEC host controller: FSM states,
// core load_status slot codes and becStatus bit positions.
package bec_pkg;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_REQ   = 4'd1;
    localparam logic [3:0] S_LOAD  = 4'd2;
    localparam logic [3:0] S_ARM   = 4'd3;
    localparam logic [3:0] S_RUN   = 4'd4;
    localparam logic [3:0] S_UNLD0 = 4'd5;
    localparam logic [3:0] S_UNLD1 = 4'd6;
    localparam logic [3:0] S_OUT   = 4'd7;
    localparam logic [3:0] S_ERR   = 4'd8;

    localparam logic [2:0] SLOT_X  = 3'd0;
    localparam logic [2:0] SLOT_Z  = 3'd1;
    localparam logic [2:0] SLOT_PX = 3'd2;
    localparam logic [2:0] SLOT_PZ = 3'd3;
    localparam logic [2:0] SLOT_W1 = 3'd4;
    localparam logic [2:0] SLOT_W0 = 3'd5;

    localparam int BS_IDLE     = 3;
    localparam int BS_DOWNLOAD = 2;
    localparam int BS_PROC     = 1;
    localparam int BS_UPLOAD   = 0;

endpackage

// File: rtl/bec_host_ctrl.sv
// Host-side sequencer for the BEC scalar-multiplication core.
// Optional watchdog: define BEC_HOST_TIMEOUT_EN.
module bec_host_ctrl
    import bec_pkg::*;
#(
    parameter int WORD_W         = 163,
    parameter int KEY_BITS       = 163,
    parameter int NUM_SLOTS      = 6,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key,
    output logic                busy,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [WORD_W-1:0]   op_data,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [WORD_W-1:0]   res_data,
    output logic                res_last,
    output logic                load_data,
    output logic [2:0]          load_status,
    output logic [WORD_W-1:0]   data_in,
    output logic                trigLoad,
    output logic                ki,
    output logic                enable,
    input  logic                next_key,
    input  logic [3:0]          becStatus,
    input  logic                done,
    input  logic [WORD_W-1:0]   data_out,
    output logic                error
);

    localparam int IW = $clog2(KEY_BITS + 1);

    logic [3:0]          state_q, state_d;
    logic [KEY_BITS-1:0] key_q, key_d;
    logic [2:0]          slot_q, slot_d;
    logic [IW-1:0]       iter_q, iter_d;
    logic [WORD_W-1:0]   w0_q, w0_d, w1_q, w1_d;
    logic                sel_q, sel_d;

`ifdef BEC_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] cnt_q, cnt_d;
    logic          timed;
`endif

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        slot_d  = slot_q;
        iter_d  = iter_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        sel_d   = sel_q;
        unique case (state_q)
            S_IDLE: if (start) begin
                key_d   = key;
                slot_d  = '0;
                iter_d  = '0;
                sel_d   = 1'b0;
                state_d = S_REQ;
            end
            S_REQ: if (becStatus[BS_DOWNLOAD]) state_d = S_LOAD;
            S_LOAD: if (op_valid) begin
                slot_d = slot_q + 3'd1;
                if (slot_q == 3'(NUM_SLOTS - 1)) state_d = S_ARM;
            end
            S_ARM: state_d = S_RUN;
            S_RUN: if (next_key) begin
                key_d  = {key_q[KEY_BITS-2:0], 1'b0};
                iter_d = iter_q + IW'(1);
                if (iter_q == IW'(KEY_BITS - 1)) state_d = S_UNLD0;
            end
            S_UNLD0: if (done) begin
                w0_d    = data_out;
                state_d = S_UNLD1;
            end
            S_UNLD1: begin
                w1_d    = data_out;
                state_d = S_OUT;
            end
            S_OUT: if (res_ready) begin
                sel_d = ~sel_q;
                if (sel_q) state_d = S_IDLE;
            end
            default: ;
        endcase
`ifdef BEC_HOST_TIMEOUT_EN
        // Watchdog only fires when the core made no progress this cycle
        timed = (state_q == S_REQ) || (state_q == S_RUN) ||
                (state_q == S_UNLD0);
        if (timed && !next_key && state_d == state_q &&
            cnt_q == TW'(TIMEOUT_CYCLES - 1))
            state_d = S_ERR;
        if (state_d != state_q || next_key) cnt_d = '0;
        else if (timed)                     cnt_d = cnt_q + TW'(1);
        else                                cnt_d = cnt_q;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            key_q   <= '0;
            slot_q  <= '0;
            iter_q  <= '0;
            w0_q    <= '0;
            w1_q    <= '0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            slot_q  <= slot_d;
            iter_q  <= iter_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            sel_q   <= sel_d;
        end
    end

`ifdef BEC_HOST_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign error = (state_q == S_ERR);

    logic unused_ok;
    assign unused_ok = ^{becStatus[BS_IDLE], becStatus[BS_PROC],
                         becStatus[BS_UPLOAD]};
`else
    assign error = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{becStatus[BS_IDLE], becStatus[BS_PROC],
                         becStatus[BS_UPLOAD], TIMEOUT_CYCLES != 0};
`endif

    always_comb begin
        busy        = (state_q != S_IDLE);
        op_ready    = 1'b0;
        res_valid   = 1'b0;
        res_data    = '0;
        res_last    = 1'b0;
        load_data   = 1'b0;
        load_status = '0;
        data_in     = '0;
        trigLoad    = 1'b0;
        ki          = 1'b0;
        enable      = 1'b0;
        unique case (state_q)
            S_REQ: load_data = 1'b1;
            S_LOAD: begin
                load_status = slot_q;
                op_ready    = 1'b1;
                trigLoad    = op_valid;
                data_in     = op_valid ? op_data : '0;
                ki          = key_q[KEY_BITS-1];
            end
            S_ARM: begin
                enable = 1'b1;
                ki     = key_q[KEY_BITS-1];
            end
            S_RUN:   ki = key_q[KEY_BITS-1];
            S_UNLD0: load_status = SLOT_X;
            S_UNLD1: load_status = SLOT_Z;
            S_OUT: begin
                res_valid = 1'b1;
                res_last  = sel_q;
                res_data  = sel_q ? w1_q : w0_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bec_host_ctrl.sv
// Directed bench for bec_host_ctrl: table-driven operand load plus
// hand sequences for key shifting, unload, backpressure, reset, timeout.
module tb_bec_host_ctrl;

    localparam int W = 163;

    logic         clk, rst, start, busy;
    logic [W-1:0] key;
    logic         op_valid, op_ready;
    logic [W-1:0] op_data;
    logic         res_valid, res_ready, res_last;
    logic [W-1:0] res_data;
    logic         load_data, trigLoad, ki, enable;
    logic [2:0]   load_status;
    logic [W-1:0] data_in;
    logic         next_key, done, error;
    logic [3:0]   becStatus;
    logic [W-1:0] data_out;

    bec_host_ctrl #(
        .WORD_W(W), .KEY_BITS(W), .NUM_SLOTS(6), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .key(key), .busy(busy),
        .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_last(res_last),
        .load_data(load_data), .load_status(load_status),
        .data_in(data_in), .trigLoad(trigLoad), .ki(ki),
        .enable(enable), .next_key(next_key), .becStatus(becStatus),
        .done(done), .data_out(data_out), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ov;
        logic [7:0] d;
        logic       trig;
        logic [2:0] ls;
    } vec_t;

    vec_t tbl[15];
    int   checks = 0;
    int   passed = 0;

    logic [W-1:0] va, vb, vc, vd, k1, k2;

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            passed++;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [W-1:0] k);
        key   = k;
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("req_busy", W'(busy), W'(1));
        chk("req_load_data", W'(load_data), W'(1));
        chk("req_op_ready", W'(op_ready), W'(0));
        tick();
        chk("req_wait_load_data", W'(load_data), W'(1));
        becStatus = 4'b0100;
        tick();
        becStatus = 4'b0000;
    endtask

    task automatic run_load(input int lo, input int hi, input logic kexp);
        for (int i = lo; i < hi; i++) begin
            op_valid = tbl[i].ov;
            op_data  = W'(tbl[i].d);
            #1;
            chk($sformatf("trig[%0d]", i), W'(trigLoad), W'(tbl[i].trig));
            chk($sformatf("ls[%0d]", i), W'(load_status), W'(tbl[i].ls));
            chk($sformatf("ready[%0d]", i), W'(op_ready), W'(1));
            if (tbl[i].trig)
                chk($sformatf("din[%0d]", i), data_in, W'(tbl[i].d));
            chk($sformatf("ki_load[%0d]", i), W'(ki), W'(kexp));
            tick();
        end
        op_valid = 1'b0;
        op_data  = '0;
        #1;
        chk("arm_enable", W'(enable), W'(1));
        chk("arm_trig", W'(trigLoad), W'(0));
        tick();
        chk("run_enable_low", W'(enable), W'(0));
    endtask

    task automatic pulses(input int n);
        next_key = 1'b1;
        repeat (n) tick();
        next_key = 1'b0;
    endtask

    task automatic unload(input logic [W-1:0] a, input logic [W-1:0] b);
        done     = 1'b1;
        data_out = a;
        tick();
        done     = 1'b0;
        data_out = b;
        #1;
        chk("unld1_status", W'(load_status), W'(1));
        tick();
        data_out = '0;
        chk("out_valid0", W'(res_valid), W'(1));
        chk("out_data0", res_data, a);
        chk("out_last0", W'(res_last), W'(0));
    endtask

    task automatic drain(input logic [W-1:0] b);
        res_ready = 1'b1;
        tick();
        chk("out_valid1", W'(res_valid), W'(1));
        chk("out_data1", res_data, b);
        chk("out_last1", W'(res_last), W'(1));
        tick();
        res_ready = 1'b0;
        chk("idle_busy", W'(busy), W'(0));
        chk("idle_valid", W'(res_valid), W'(0));
    endtask

    initial begin
        tbl[0]  = '{1'b1, 8'h01, 1'b1, 3'd0};
        tbl[1]  = '{1'b1, 8'h02, 1'b1, 3'd1};
        tbl[2]  = '{1'b1, 8'h03, 1'b1, 3'd2};
        tbl[3]  = '{1'b1, 8'h04, 1'b1, 3'd3};
        tbl[4]  = '{1'b1, 8'h05, 1'b1, 3'd4};
        tbl[5]  = '{1'b1, 8'h06, 1'b1, 3'd5};
        tbl[6]  = '{1'b1, 8'h11, 1'b1, 3'd0};
        tbl[7]  = '{1'b0, 8'h22, 1'b0, 3'd1};
        tbl[8]  = '{1'b1, 8'h22, 1'b1, 3'd1};
        tbl[9]  = '{1'b1, 8'h33, 1'b1, 3'd2};
        tbl[10] = '{1'b0, 8'h44, 1'b0, 3'd3};
        tbl[11] = '{1'b0, 8'h44, 1'b0, 3'd3};
        tbl[12] = '{1'b1, 8'h44, 1'b1, 3'd3};
        tbl[13] = '{1'b1, 8'h55, 1'b1, 3'd4};
        tbl[14] = '{1'b1, 8'h66, 1'b1, 3'd5};

        va = {3'b101, {5{32'hDEADBEEF}}};
        vb = {3'b010, {5{32'h12345678}}};
        vc = {3'b110, {5{32'hCAFEF00D}}};
        vd = {3'b011, {5{32'h0BADC0DE}}};
        k1 = W'(1);
        k2 = '0;
        k2[W-1] = 1'b1;

        rst = 1'b0; start = 1'b0; key = '0; op_valid = 1'b0;
        op_data = '0; res_ready = 1'b0; next_key = 1'b0;
        becStatus = '0; done = 1'b0; data_out = '0;
        #3;
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_res_valid", W'(res_valid), W'(0));
        chk("rst_error", W'(error), W'(0));
        chk("rst_load_data", W'(load_data), W'(0));
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Job 1: key=1, six back-to-back operands, result backpressure
        start_job(k1);
        run_load(0, 6, 1'b0);
        chk("j1_ki_start", W'(ki), W'(0));
        pulses(162);
        #1;
        chk("j1_ki_after162", W'(ki), W'(1));
        pulses(1);
        next_key = 1'b1;
        #1;
        chk("unld0_status", W'(load_status), W'(0));
        chk("unld0_ki", W'(ki), W'(0));
        tick();
        next_key = 1'b0;
        chk("unld0_hold_busy", W'(busy), W'(1));
        chk("unld0_hold_valid", W'(res_valid), W'(0));
        unload(va, vb);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("stall_valid[%0d]", i), W'(res_valid), W'(1));
            chk($sformatf("stall_data[%0d]", i), res_data, va);
        end
        drain(vb);

        // Job 2: MSB-only key, operand stalls, immediate result drain
        start_job(k2);
        run_load(6, 15, 1'b1);
        chk("j2_ki_start", W'(ki), W'(1));
        tick();
        chk("j2_ki_no_pulse", W'(ki), W'(1));
        pulses(1);
        #1;
        chk("j2_ki_after1", W'(ki), W'(0));
        pulses(1);
        #1;
        chk("j2_ki_after2", W'(ki), W'(0));
        pulses(161);
        #1;
        chk("j2_unld0_status", W'(load_status), W'(0));
        unload(vb, va);
        drain(va);

        // Job 3: reset during RUN, then a clean job
        start_job(k1);
        run_load(0, 6, 1'b0);
        pulses(50);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", W'(busy), W'(0));
        chk("mid_rst_ki", W'(ki), W'(0));
        chk("mid_rst_enable", W'(enable), W'(0));
        chk("mid_rst_valid", W'(res_valid), W'(0));
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_idle", W'(busy), W'(0));
        start_job(k1);
        run_load(0, 6, 1'b0);
        pulses(163);
        #1;
        chk("j3_valid_before", W'(res_valid), W'(0));
        unload(vc, vd);
        drain(vd);

        // Job 4: core stops issuing next_key in RUN
        start_job(k1);
        run_load(0, 6, 1'b0);
`ifdef BEC_HOST_TIMEOUT_EN
        repeat (15) tick();
        chk("tmo_err_early", W'(error), W'(0));
        tick();
        chk("tmo_err", W'(error), W'(1));
        chk("tmo_enable", W'(enable), W'(0));
        chk("tmo_load_data", W'(load_data), W'(0));
        chk("tmo_trig", W'(trigLoad), W'(0));
        tick();
        chk("tmo_sticky", W'(error), W'(1));
`else
        repeat (20) tick();
        chk("wait_no_error", W'(error), W'(0));
        chk("wait_busy", W'(busy), W'(1));
`endif
        rst = 1'b0;
        #1;
        chk("final_rst_error", W'(error), W'(0));
        rst = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/bec_host_ctrl.md
BEC_HOST_CTRL -- requirements
Module: bec_host_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 163, operand/result word width.
REQ-002 SHALL have parameter KEY_BITS, default 163, scalar length; one bit per core iteration.
REQ-003 SHALL have parameter NUM_SLOTS, default 6, operand words loaded per job (slots 0..5).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096, max cycles between core events (only with BEC_HOST_TIMEOUT_EN).
REQ-005 SHALL have one clock and one reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-low reset.
REQ-006 Host side: start in 1 job request; key in KEY_BITS scalar, sampled at start; busy out 1.
REQ-007 Operand stream: op_valid in 1; op_ready out 1; op_data in WORD_W, words in slot order 0..5.
REQ-008 Result stream: res_valid out 1; res_ready in 1; res_data out WORD_W; res_last out 1, high on second word.
REQ-009 Core side: load_data out 1; load_status out 3; data_in out WORD_W; trigLoad out 1; ki out 1; enable out 1.
REQ-010 Core side: next_key in 1; becStatus in 4, {idle,download,proc,upload}; done in 1; data_out in WORD_W.
REQ-011 error out 1, sticky timeout flag (tied 0 without BEC_HOST_TIMEOUT_EN).

Function
REQ-012 FSM states SHALL be IDLE, REQ, LOAD, ARM, RUN, UNLD0, UNLD1, OUT, ERR.
REQ-013 IDLE: start=1 latches key into shift reg, clears counters, -> REQ; start while busy ignored.
REQ-014 REQ: load_data=1 until becStatus[2]=1, then -> LOAD.
REQ-015 LOAD: load_status=slot counter; op_ready=1; on op_valid&op_ready: data_in=op_data, trigLoad=1 same cycle, slot++; after slot NUM_SLOTS-1 -> ARM.
REQ-016 trigLoad SHALL be combinational op_valid&op_ready in LOAD, 0 elsewhere; op_ready=0 outside LOAD.
REQ-017 ki SHALL equal key shift-reg MSB (key[KEY_BITS-1] initially) from LOAD through RUN.
REQ-018 ARM: enable=1 exactly one cycle, -> RUN.
REQ-019 RUN: each next_key=1 cycle shifts key left one (ki updated next cycle), iter++; after KEY_BITS pulses -> UNLD0.
REQ-020 UNLD0: load_status=3'b000; when done=1 capture data_out into buffer word0, -> UNLD1.
REQ-021 UNLD1: load_status=3'b001 one cycle, capture data_out into word1 same cycle (returns core to idle), -> OUT.
REQ-022 OUT: res_valid=1, word0 then word1; advance on res_valid&res_ready; res_last=1 with word1; after word1 accepted -> IDLE.
REQ-023 busy=1 in every state except IDLE.
REQ-024 Operand stall (op_valid=0) SHALL hold slot and load_status; no timeout applies in LOAD or OUT.
REQ-025 next_key outside RUN SHALL be ignored; iter SHALL never exceed KEY_BITS.

Reset
REQ-026 rst=0 SHALL asynchronously force IDLE and zero all outputs, key shift reg, slot/iter counters, result buffer, error.
REQ-027 Reset mid-job SHALL abandon the job; no res_valid until a new start completes.

Configuration
REQ-028 Macro BEC_HOST_TIMEOUT_EN defined: cycle counter clears on each state change or next_key; reaching TIMEOUT_CYCLES in REQ, RUN or UNLD0 -> ERR, error=1, all core outputs 0; ERR exits only via reset.
REQ-029 BEC_HOST_TIMEOUT_EN undefined: no counter, no ERR entry, error=0, waits unbounded.

Structure
REQ-030 Shared package bec_pkg SHALL hold state encoding, load_status slot constants (SLOT_X=0..SLOT_W0=5) and becStatus bit indices.
REQ-031 Single module, no sub-module; optional bec_host_timer not instantiated.

Verification
REQ-032 start, key=163'h1, six words 1..6 with op_valid held -> trigLoad 6 consecutive cycles, load_status 0..5, enable one pulse.
REQ-033 Key=163'h4_0000...0 (MSB=1, bit160=0) -> ki=1 before first next_key, 0 after second next_key.
REQ-034 Core model returns data_out=A at 000 and B at 001 -> res_data A (res_last=0) then B (res_last=1).
REQ-035 res_ready=0 for 10 cycles in OUT -> res_valid/res_data held stable; IDLE only after word1 accepted.
REQ-036 rst=0 asserted in RUN after 50 next_key pulses -> outputs 0 immediately, fresh job completes normally.
REQ-037 BEC_HOST_TIMEOUT_EN, TIMEOUT_CYCLES=16, no next_key in RUN -> error=1 on cycle 16, enable/load_data/trigLoad 0.
